// File: rtl/ssd_bcd_scan_driver.sv
// Seven-segment score display engine: sequential binary-to-BCD (double dabble)
// feeding an atomically updated display register that is scanned across common-anode digits.
module ssd_bcd_scan_driver #(
    parameter int unsigned BIN_W         = 16,
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV   = 17,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    logic [1:0]             state_q, state_nxt;
    logic [BIN_W-1:0]       bin_q, bin_nxt;
    logic [BCD_W-1:0]       bcd_q, bcd_nxt, bcd_adj;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic                   ovf_acc_q, ovf_acc_nxt;
    logic                   pend_q, pend_nxt;
    logic [BIN_W-1:0]       pend_val_q, pend_val_nxt;
    logic [BCD_W-1:0]       disp_q, disp_nxt;
    logic                   busy_nxt, done_nxt, ovf_nxt;

    logic [REFRESH_DIV-1:0] presc_q, presc_nxt;
    logic [IDX_W-1:0]       idx_q, idx_nxt;
    logic [NUM_DIGITS-1:0]  an_nxt;
    logic [6:0]             seg_nxt;
    logic                   dp_nxt;
    logic [NUM_DIGITS:0]    zero_above;
    logic [3:0]             cur_digit;
    logic                   cur_blank;

    // Conversion FSM and datapath next-state.
    always_comb begin
        state_nxt    = state_q;
        bin_nxt      = bin_q;
        bcd_nxt      = bcd_q;
        cnt_nxt      = cnt_q;
        ovf_acc_nxt  = ovf_acc_q;
        pend_nxt     = pend_q;
        pend_val_nxt = pend_val_q;
        disp_nxt     = disp_q;
        ovf_nxt      = overflow;
        done_nxt     = 1'b0;
        bcd_adj      = bcd_q;

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_nxt     = value;
                    bcd_nxt     = '0;
                    ovf_acc_nxt = 1'b0;
                    cnt_nxt     = CNT_W'(BIN_W);
                    state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_nxt     = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_nxt     = bin_q << 1;
                ovf_acc_nxt = ovf_acc_q | bcd_adj[BCD_W-1];
                cnt_nxt     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = S_COMMIT;
                end
                if (load) begin
                    pend_nxt     = 1'b1;
                    pend_val_nxt = value;
                end
            end
            S_COMMIT: begin
                disp_nxt = bcd_q;
                ovf_nxt  = ovf_acc_q;
                done_nxt = 1'b1;
                // A request that lands during COMMIT is newer than any pending one.
                if (pend_q || load) begin
                    bin_nxt     = load ? value : pend_val_q;
                    bcd_nxt     = '0;
                    ovf_acc_nxt = 1'b0;
                    cnt_nxt     = CNT_W'(BIN_W);
                    pend_nxt    = 1'b0;
                    state_nxt   = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt == S_SHIFT) || (state_nxt == S_COMMIT);
    end

    // Scan index, leading-zero blanking and segment decode.
    always_comb begin
        presc_nxt = presc_q + 1'b1;
        idx_nxt   = idx_q;
        if (&presc_q) begin
            idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        zero_above[NUM_DIGITS] = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] && (disp_q[4*k +: 4] == 4'd0);
        end

        an_nxt    = '1;
        dp_nxt    = 1'b1;
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                an_nxt[k] = 1'b0;
                dp_nxt    = ~dp_mask[k];
                cur_digit = disp_q[4*k +: 4];
                cur_blank = (BLANK_LEADING != 0) && (k > 0) && zero_above[k];
            end
        end

        if (overflow) begin
            seg_nxt = SEG_DASH;
        end else if (cur_blank) begin
            seg_nxt = SEG_BLANK;
        end else begin
            case (cur_digit)
                4'd0:    seg_nxt = 7'b0000001;
                4'd1:    seg_nxt = 7'b1001111;
                4'd2:    seg_nxt = 7'b0010010;
                4'd3:    seg_nxt = 7'b0000110;
                4'd4:    seg_nxt = 7'b1001100;
                4'd5:    seg_nxt = 7'b0100100;
                4'd6:    seg_nxt = 7'b0100000;
                4'd7:    seg_nxt = 7'b0001111;
                4'd8:    seg_nxt = 7'b0000000;
                4'd9:    seg_nxt = 7'b0000100;
                default: seg_nxt = SEG_BLANK;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            disp_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            bin_q      <= bin_nxt;
            bcd_q      <= bcd_nxt;
            cnt_q      <= cnt_nxt;
            ovf_acc_q  <= ovf_acc_nxt;
            pend_q     <= pend_nxt;
            pend_val_q <= pend_val_nxt;
            disp_q     <= disp_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            overflow   <= ovf_nxt;
            presc_q    <= presc_nxt;
            idx_q      <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_bcd_scan_driver.sv
// Scoreboard bench for ssd_bcd_scan_driver: an 8-digit and a 4-digit instance share stimulus.
module tb_ssd_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [7:0]  dp_mask;

    logic       busy8, done8, ovf8, dp8;
    logic [7:0] an8;
    logic [6:0] seg8;
    logic       busy4, done4, ovf4, dp4;
    logic [3:0] an4;
    logic [6:0] seg4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int unsigned exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    ssd_bcd_scan_driver #(.BIN_W(16), .NUM_DIGITS(8), .REFRESH_DIV(2), .BLANK_LEADING(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask),
        .busy(busy8), .done(done8), .overflow(ovf8), .an(an8), .seg(seg8), .dp(dp8)
    );

    ssd_bcd_scan_driver #(.BIN_W(16), .NUM_DIGITS(4), .REFRESH_DIV(2), .BLANK_LEADING(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask[3:0]),
        .busy(busy4), .done(done4), .overflow(ovf4), .an(an4), .seg(seg4), .dp(dp4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int unsigned v, input int k, input int n);
        longint unsigned p = 1;
        longint unsigned lim = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        for (int i = 0; i < n; i++) lim = lim * 10;
        if (longint'(v) >= lim) return 7'b1111110;
        if (k > 0 && longint'(v) < p) return 7'b1111111;
        return seg_tab[int'((longint'(v) / p) % 10)];
    endfunction

    // Scoreboard: every done pulse consumes the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            int unsigned v;
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            chk("done4_sync", done4, 1);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                v = exp_q.pop_front();
                chk("ovf8", ovf8, (v >= 100000000) ? 1 : 0);
                chk("ovf4", ovf4, (v >= 10000) ? 1 : 0);
            end
        end
    end

    task automatic pulse_load(input int unsigned v);
        @(negedge clk);
        value = 16'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        load_cyc = cyc;
    endtask

    task automatic do_load(input int unsigned v);
        exp_q.push_back(v);
        pulse_load(v);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("done_timeout", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_disp(input int unsigned v, input string name);
        logic [7:0] s8 [8];
        logic [7:0] s4 [4];
        int bad_an = 0;
        int bad_dp = 0;
        for (int k = 0; k < 8; k++) s8[k] = 8'h80;
        for (int k = 0; k < 4; k++) s4[k] = 8'h80;
        repeat (80) begin
            @(negedge clk);
            if ($countones(~an8) != 1) bad_an++;
            if ($countones(~an4) != 1) bad_an++;
            for (int k = 0; k < 8; k++) begin
                if (an8 == ~(8'b1 << k)) begin
                    s8[k] = {1'b0, seg8};
                    if (dp8 != ~dp_mask[k]) bad_dp++;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (an4 == ~(4'b1 << k)) begin
                    s4[k] = {1'b0, seg4};
                    if (dp4 != ~dp_mask[k]) bad_dp++;
                end
            end
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_seg8_d%0d", name, k), s8[k], {1'b0, exp_seg(v, k, 8)});
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_seg4_d%0d", name, k), s4[k], {1'b0, exp_seg(v, k, 4)});
        chk($sformatf("%s_an_onehot", name), bad_an, 0);
        chk($sformatf("%s_dp", name), bad_dp, 0);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        load = 1'b0;
        value = '0;
        dp_mask = '0;

        // Reset values.
        repeat (5) @(negedge clk);
        chk("rst_an8", an8, 8'hFF);
        chk("rst_an4", an4, 4'hF);
        chk("rst_seg", seg8, 7'h7F);
        chk("rst_dp", dp8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_ovf", ovf8, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_an", an8, 8'hFE);
        chk("post_rst_seg", seg8, 7'b0000001);
        chk("post_rst_busy", busy8, 0);
        check_disp(0, "reset");

        // Latency and first conversion.
        n0 = done_cnt;
        do_load(2048);
        chk("busy_after_load", busy8, 1);
        wait_dones(n0 + 1, 60);
        chk("latency", last_done_cyc - load_cyc, 17);
        repeat (2) @(negedge clk);
        chk("idle_busy", busy8, 0);
        check_disp(2048, "v2048");

        // Zero and full-scale input.
        n0 = done_cnt;
        do_load(0);
        wait_dones(n0 + 1, 60);
        repeat (2) @(negedge clk);
        check_disp(0, "v0");
        n0 = done_cnt;
        do_load(65535);
        wait_dones(n0 + 1, 60);
        repeat (2) @(negedge clk);
        check_disp(65535, "v65535");

        // Overflow on the 4-digit instance, then the largest value it can show.
        dp_mask = 8'h81;
        n0 = done_cnt;
        do_load(12345);
        wait_dones(n0 + 1, 60);
        repeat (2) @(negedge clk);
        check_disp(12345, "v12345");
        n0 = done_cnt;
        do_load(9999);
        wait_dones(n0 + 1, 60);
        repeat (2) @(negedge clk);
        check_disp(9999, "v9999");
        dp_mask = 8'h00;

        // Loads while busy: latest pending value wins, restart without an idle cycle.
        n0 = done_cnt;
        do_load(100);
        repeat (1) @(negedge clk);
        pulse_load(7);
        pulse_load(42);
        exp_q.push_back(42);
        wait_dones(n0 + 2, 100);
        chk("pend_gap", last_done_cyc - prev_done_cyc, 17);
        repeat (30) @(negedge clk);
        chk("pend_done_count", done_cnt - n0, 2);
        check_disp(42, "v42");

        // Reset in the middle of a conversion with a pending request.
        dp_mask = 8'h02;
        do_load(100);
        pulse_load(7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_an", an8, 8'hFF);
        exp_q.delete();
        n0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_cnt - n0, 0);
        chk("midrst_busy_after", busy8, 0);
        check_disp(0, "midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
